// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ex_operand_stage_pkg                                   |
// | Purpose : shared widths, ALU control codes, forward select enum  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ex_operand_stage_pkg;

    localparam int XLEN        = 32;
    localparam int CTRL_W      = 6;
    localparam int REG_AW      = 5;
    localparam int STALL_CNT_W = 16;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_SUB    = 6'b000001;
    localparam logic [5:0] ALU_AND    = 6'b000010;
    localparam logic [5:0] ALU_OR     = 6'b000011;
    localparam logic [5:0] ALU_XOR    = 6'b000100;
    localparam logic [5:0] ALU_SLL    = 6'b000101;
    localparam logic [5:0] ALU_SRL    = 6'b000110;
    localparam logic [5:0] ALU_SRA    = 6'b000111;
    localparam logic [5:0] ALU_SLT    = 6'b001000;
    localparam logic [5:0] ALU_SLTU   = 6'b001001;
    localparam logic [5:0] ALU_PASS_B = 6'b010111;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_e;

endpackage : ex_operand_stage_pkg
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : operand_fwd_mux                                        |
// | Purpose : per-source forward hit detection and priority select   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module operand_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr_i,
    input  logic [W-1:0]  src_data_i,
    input  logic          exm_reg_write_i,
    input  logic          exm_is_load_i,
    input  logic [AW-1:0] exm_rd_i,
    input  logic [W-1:0]  exm_result_i,
    input  logic          mwb_reg_write_i,
    input  logic [AW-1:0] mwb_rd_i,
    input  logic [W-1:0]  mwb_result_i,
    output fwd_sel_e      sel_o,
    output logic          refresh_o,
    output logic [W-1:0]  data_o
);

    logic w_exm_hit;
    logic w_mwb_hit;

    assign w_exm_hit = exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == src_addr_i);
    assign w_mwb_hit = mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == src_addr_i);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        sel_o = FWD_NONE;
        if (w_exm_hit) begin
            sel_o = FWD_EXM;
        end else if (w_mwb_hit) begin
            sel_o = FWD_MWB;
        end
    end

    always_comb begin
        data_o = src_data_i;
        case (sel_o)
            FWD_EXM: data_o = exm_result_i;
            FWD_MWB: data_o = mwb_result_i;
            default: data_o = src_data_i;
        endcase
    end

    // A load result on EX/MEM is only an address, never worth storing.
    assign refresh_o = (sel_o == FWD_MWB) || ((sel_o == FWD_EXM) && !exm_is_load_i);

endmodule : operand_fwd_mux
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ex_operand_stage                                       |
// | Purpose : ID/EX register with forwarding, operand select, and    |
// |           load-use bubble insertion                              |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN        = ex_operand_stage_pkg::XLEN,
    parameter int CTRL_W      = ex_operand_stage_pkg::CTRL_W,
    parameter int REG_AW      = ex_operand_stage_pkg::REG_AW,
    parameter int STALL_CNT_W = ex_operand_stage_pkg::STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [REG_AW-1:0]      id_rs1_addr,
    input  logic [REG_AW-1:0]      id_rs2_addr,
    input  logic [XLEN-1:0]        id_rs1_data,
    input  logic [XLEN-1:0]        id_rs2_data,
    input  logic [XLEN-1:0]        id_imm,
    input  logic                   id_use_imm,
    input  logic                   id_use_pc,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [CTRL_W-1:0]      id_alu_ctrl,
    input  logic [REG_AW-1:0]      id_rd_addr,
    input  logic                   id_reg_write,
    input  logic                   exm_reg_write,
    input  logic                   exm_is_load,
    input  logic [REG_AW-1:0]      exm_rd,
    input  logic [XLEN-1:0]        exm_result,
    input  logic                   mwb_reg_write,
    input  logic [REG_AW-1:0]      mwb_rd,
    input  logic [XLEN-1:0]        mwb_result,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        alu_rs1,
    output logic [XLEN-1:0]        alu_rs2,
    output logic [CTRL_W-1:0]      alu_ctrl,
    output logic [REG_AW-1:0]      ex_rd_addr,
    output logic                   ex_reg_write,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   valid_q,     valid_d;
    logic [REG_AW-1:0]      rs1_addr_q,  rs2_addr_q;
    logic [XLEN-1:0]        rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]        rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]        imm_q,       pc_q;
    logic                   use_imm_q,   use_pc_q;
    logic [CTRL_W-1:0]      alu_ctrl_q;
    logic [REG_AW-1:0]      rd_q;
    logic                   reg_write_q;
    logic [STALL_CNT_W-1:0] stall_q,     stall_d;

    fwd_sel_e               w_rs1_sel,   w_rs2_sel;
    logic                   w_rs1_refresh, w_rs2_refresh;
    logic [XLEN-1:0]        w_rs1_fwd,   w_rs2_fwd;
    logic                   w_hazard;
    logic                   w_advance;
    logic                   w_capture;

    operand_fwd_mux #(.W(XLEN), .AW(REG_AW)) u_fwd_rs1 (
        .src_addr_i      (rs1_addr_q),
        .src_data_i      (rs1_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_is_load_i   (exm_is_load),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .sel_o           (w_rs1_sel),
        .refresh_o       (w_rs1_refresh),
        .data_o          (w_rs1_fwd)
    );

    operand_fwd_mux #(.W(XLEN), .AW(REG_AW)) u_fwd_rs2 (
        .src_addr_i      (rs2_addr_q),
        .src_data_i      (rs2_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_is_load_i   (exm_is_load),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .sel_o           (w_rs2_sel),
        .refresh_o       (w_rs2_refresh),
        .data_o          (w_rs2_fwd)
    );

    // Sources masked by PC/immediate selection cannot cause a load-use stall.
    assign w_hazard = valid_q && exm_is_load && exm_reg_write && (exm_rd != '0) &&
                      (((exm_rd == rs1_addr_q) && !use_pc_q) ||
                       ((exm_rd == rs2_addr_q) && !use_imm_q));

    assign ex_valid  = valid_q && !w_hazard;
    assign w_advance = ex_valid && ex_ready;
    assign id_ready  = !valid_q || w_advance;
    assign w_capture = id_valid && id_ready && !flush;

    assign alu_rs1      = use_pc_q  ? pc_q  : w_rs1_fwd;
    assign alu_rs2      = use_imm_q ? imm_q : w_rs2_fwd;
    assign alu_ctrl     = alu_ctrl_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = reg_write_q && ex_valid;
    assign stall_cycles = stall_q;

    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        stall_d    = stall_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (w_capture) begin
            valid_d = 1'b1;
        end else if (w_advance) begin
            valid_d = 1'b0;
        end

        if (w_capture) begin
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
        end else if (valid_q && !w_advance) begin
            // Latch forwarded values so a stalled entry survives producer retirement.
            if (w_rs1_refresh) rs1_data_d = w_rs1_fwd;
            if (w_rs2_refresh) rs2_data_d = w_rs2_fwd;
        end

        if (w_hazard && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            alu_ctrl_q  <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            stall_q    <= stall_d;
            if (w_capture) begin
                rs1_addr_q  <= id_rs1_addr;
                rs2_addr_q  <= id_rs2_addr;
                imm_q       <= id_imm;
                pc_q        <= id_pc;
                use_imm_q   <= id_use_imm;
                use_pc_q    <= id_use_pc;
                alu_ctrl_q  <= id_alu_ctrl;
                rd_q        <= id_rd_addr;
                reg_write_q <= id_reg_write;
            end
        end
    end

endmodule : ex_operand_stage
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ex_operand_stage                                    |
// | Purpose : directed self-checking bench for ex_operand_stage      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_use_imm, id_use_pc, id_reg_write;
    logic [5:0]  id_alu_ctrl;
    logic        exm_reg_write, exm_is_load;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] alu_rs1, alu_rs2;
    logic [5:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_use_imm    (id_use_imm),
        .id_use_pc     (id_use_pc),
        .id_pc         (id_pc),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_rd_addr    (id_rd_addr),
        .id_reg_write  (id_reg_write),
        .exm_reg_write (exm_reg_write),
        .exm_is_load   (exm_is_load),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .alu_rs1       (alu_rs1),
        .alu_rs2       (alu_rs2),
        .alu_ctrl      (alu_ctrl),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .stall_cycles  (stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        exm_reg_write = 1'b0; exm_is_load = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [5:0] ctrl,
                         input logic upc, input logic uimm,
                         input logic [31:0] pc, input logic [31:0] imm);
        id_valid = 1'b1; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
        id_rd_addr = rd; id_alu_ctrl = ctrl; id_use_pc = upc; id_use_imm = uimm;
        id_pc = pc; id_imm = imm; id_reg_write = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid: got=%b exp=0", ex_valid); end
        total++; if (alu_rs1 !== 32'h0) begin bad++; $display("FAIL rst_alu_rs1: got=%h exp=0", alu_rs1); end
        total++; if (alu_rs2 !== 32'h0) begin bad++; $display("FAIL rst_alu_rs2: got=%h exp=0", alu_rs2); end
        total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL rst_stall: got=%h exp=0", stall_cycles); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL rst_id_ready: got=%b exp=1", id_ready); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL rst_ex_reg_write: got=%b exp=0", ex_reg_write); end
        total++; if (alu_ctrl !== 6'h0) begin bad++; $display("FAIL rst_alu_ctrl: got=%h exp=0", alu_ctrl); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd_priority();
        ex_ready = 1'b0;
        offer(5'd5, 32'h99, 5'd6, 32'h66, 5'd9, ALU_SUB, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        id_valid = 1'b0;
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h11;
        mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'h22;
        #1;
        total++; if (alu_rs1 !== 32'h11) begin bad++; $display("FAIL prio_exm: alu_rs1=%h exp=11", alu_rs1); end
        total++; if (alu_rs2 !== 32'h66) begin bad++; $display("FAIL prio_rs2_reg: alu_rs2=%h exp=66", alu_rs2); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL prio_ex_valid: got=%b exp=1", ex_valid); end
        total++; if (ex_reg_write !== 1'b1) begin bad++; $display("FAIL prio_reg_write: got=%b exp=1", ex_reg_write); end
        total++; if (alu_ctrl !== ALU_SUB) begin bad++; $display("FAIL prio_alu_ctrl: got=%h exp=%h", alu_ctrl, ALU_SUB); end
        total++; if (ex_rd_addr !== 5'd9) begin bad++; $display("FAIL prio_rd: got=%0d exp=9", ex_rd_addr); end
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL prio_id_ready: got=%b exp=0", id_ready); end
        exm_rd = 5'd0;
        #1;
        total++; if (alu_rs1 !== 32'h22) begin bad++; $display("FAIL prio_mwb: alu_rs1=%h exp=22", alu_rs1); end
        ex_ready = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL prio_ready_adv: got=%b exp=1", id_ready); end
        tick();
        clear_fwd();
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL prio_drain: ex_valid=%b exp=0", ex_valid); end
    endtask

    task automatic test_x0();
        offer(5'd0, 32'h0, 5'd3, 32'h33, 5'd1, ALU_ADD, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        id_valid = 1'b0;
        exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hFFFF;
        mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_result = 32'h1234;
        #1;
        total++; if (alu_rs1 !== 32'h0) begin bad++; $display("FAIL x0_rs1: got=%h exp=0", alu_rs1); end
        total++; if (alu_rs2 !== 32'h33) begin bad++; $display("FAIL x0_rs2: got=%h exp=33", alu_rs2); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL x0_ex_valid: got=%b exp=1", ex_valid); end
        tick();
        clear_fwd();
    endtask

    task automatic test_use_imm_pc();
        offer(5'd5, 32'hAAAA, 5'd5, 32'hBBBB, 5'd2, ALU_PASS_B, 1'b1, 1'b1, 32'h1000, 32'hFFFF_FFF0);
        tick();
        id_valid = 1'b0;
        exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'hDEAD;
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL immpc_no_hazard: ex_valid=%b exp=1", ex_valid); end
        total++; if (alu_rs1 !== 32'h1000) begin bad++; $display("FAIL immpc_rs1: got=%h exp=1000", alu_rs1); end
        total++; if (alu_rs2 !== 32'hFFFF_FFF0) begin bad++; $display("FAIL immpc_rs2: got=%h exp=fffffff0", alu_rs2); end
        total++; if (alu_ctrl !== 6'b010111) begin bad++; $display("FAIL immpc_ctrl: got=%h exp=17", alu_ctrl); end
        tick();
        clear_fwd();
        #1;
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL immpc_stall: got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_load_use();
        offer(5'd1, 32'h10, 5'd7, 32'h70, 5'd8, ALU_OR, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        id_valid = 1'b0;
        exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd7; exm_result = 32'hDEAD;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: ex_valid=%b exp=0", ex_valid); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL lu_reg_write: got=%b exp=0", ex_reg_write); end
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_id_ready: got=%b exp=0", id_ready); end
        total++; if (ex_rd_addr !== 5'd8) begin bad++; $display("FAIL lu_rd_held: got=%0d exp=8", ex_rd_addr); end
        total++; if (alu_ctrl !== ALU_OR) begin bad++; $display("FAIL lu_ctrl_held: got=%h exp=%h", alu_ctrl, ALU_OR); end
        tick();
        clear_fwd();
        mwb_reg_write = 1'b1; mwb_rd = 5'd7; mwb_result = 32'hABCD;
        #1;
        total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt: got=%0d exp=1", stall_cycles); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_release: ex_valid=%b exp=1", ex_valid); end
        total++; if (alu_rs2 !== 32'hABCD) begin bad++; $display("FAIL lu_rs2_fwd: got=%h exp=abcd", alu_rs2); end
        total++; if (alu_rs1 !== 32'h10) begin bad++; $display("FAIL lu_rs1_reg: got=%h exp=10", alu_rs1); end
        tick();
        clear_fwd();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        offer(5'd4, 32'h40, 5'd2, 32'h20, 5'd3, ALU_AND, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        offer(5'd0, 32'h77, 5'd0, 32'h88, 5'd12, ALU_XOR, 1'b0, 1'b0, 32'h0, 32'h0);
        mwb_reg_write = 1'b1; mwb_rd = 5'd4; mwb_result = 32'h55;
        #1;
        total++; if (alu_rs1 !== 32'h55) begin bad++; $display("FAIL bp_fwd: alu_rs1=%h exp=55", alu_rs1); end
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_ready1: got=%b exp=0", id_ready); end
        tick();
        mwb_reg_write = 1'b0;
        #1;
        total++; if (alu_rs1 !== 32'h55) begin bad++; $display("FAIL bp_retired: alu_rs1=%h exp=55", alu_rs1); end
        total++; if (ex_rd_addr !== 5'd3) begin bad++; $display("FAIL bp_no_capture: rd=%0d exp=3", ex_rd_addr); end
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2: got=%b exp=0", id_ready); end
        tick();
        total++; if (alu_rs1 !== 32'h55) begin bad++; $display("FAIL bp_hold3: alu_rs1=%h exp=55", alu_rs1); end
        total++; if (alu_rs2 !== 32'h20) begin bad++; $display("FAIL bp_rs2: alu_rs2=%h exp=20", alu_rs2); end
        ex_ready = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_adv: got=%b exp=1", id_ready); end
        tick();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got=%b exp=1", ex_valid); end
        total++; if (alu_rs1 !== 32'h77) begin bad++; $display("FAIL b2b_rs1: got=%h exp=77", alu_rs1); end
        total++; if (alu_rs2 !== 32'h88) begin bad++; $display("FAIL b2b_rs2: got=%h exp=88", alu_rs2); end
        total++; if (ex_rd_addr !== 5'd12) begin bad++; $display("FAIL b2b_rd: got=%0d exp=12", ex_rd_addr); end
    endtask

    task automatic test_flush();
        offer(5'd9, 32'h5A, 5'd9, 32'h5A, 5'd20, ALU_SLL, 1'b0, 1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_held: got=%b exp=0", id_ready); end
        tick();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got=%b exp=0", ex_valid); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL fl_reg_write: got=%b exp=0", ex_reg_write); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL fl_ready: got=%b exp=1", id_ready); end
        total++; if (ex_rd_addr !== 5'd12) begin bad++; $display("FAIL fl_no_capture: rd=%0d exp=12", ex_rd_addr); end
        offer(5'd9, 32'h5A, 5'd9, 32'h5A, 5'd21, ALU_SRL, 1'b0, 1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL fl_ready_empty: got=%b exp=1", id_ready); end
        tick();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_empty_valid: got=%b exp=0", ex_valid); end
        total++; if (ex_rd_addr !== 5'd12) begin bad++; $display("FAIL fl_empty_rd: rd=%0d exp=12", ex_rd_addr); end
        ex_ready = 1'b1;
    endtask

    task automatic test_stall_saturation();
        offer(5'd7, 32'h0, 5'd0, 32'h0, 5'd4, ALU_ADD, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        id_valid = 1'b0;
        exm_is_load = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd7;
        repeat (65533) tick();
        total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got=%h exp=fffe", stall_cycles); end
        tick();
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got=%h exp=ffff", stall_cycles); end
        repeat (2) tick();
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got=%h exp=ffff", stall_cycles); end
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL sat_bubble: got=%b exp=0", ex_valid); end
        clear_fwd();
        tick();
    endtask

    task automatic test_reset_midstream();
        ex_ready = 1'b0;
        offer(5'd0, 32'h1234, 5'd0, 32'h5678, 5'd5, ALU_SLT, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        id_valid = 1'b0;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got=%b exp=1", ex_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got=%b exp=0", ex_valid); end
        total++; if (alu_rs1 !== 32'h0) begin bad++; $display("FAIL mid_rs1: got=%h exp=0", alu_rs1); end
        total++; if (alu_rs2 !== 32'h0) begin bad++; $display("FAIL mid_rs2: got=%h exp=0", alu_rs2); end
        total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL mid_stall: got=%h exp=0", stall_cycles); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got=%b exp=1", id_ready); end
        total++; if (ex_rd_addr !== 5'd0) begin bad++; $display("FAIL mid_rd: got=%0d exp=0", ex_rd_addr); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped: got=%b exp=0", ex_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_pc = '0; id_use_imm = 1'b0; id_use_pc = 1'b0;
        id_alu_ctrl = '0; id_rd_addr = '0; id_reg_write = 1'b0;
        clear_fwd();

        test_reset();
        test_fwd_priority();
        test_x0();
        test_use_imm_pc();
        test_load_use();
        test_backpressure();
        test_flush();
        test_stall_saturation();
        test_reset_midstream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ex_operand_stage
`default_nettype wire
